// File: rtl/velocity_uart_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : velocity_uart_streamer
//  Description : Samples the decoder's signed 16-bit velocity once per frame
//                period and sends each sample as a 5-byte packet over a
//                UART 8N1 line:
//                  A5, seq, vel[15:8], vel[7:0], seq^vel[15:8]^vel[7:0]
//                A frame tick that arrives while a packet is still in flight
//                is dropped and raises the sticky overrun flag.
//  Ports       : clk         - system clock
//                rst         - asynchronous active-high reset
//                vel_in      - velocity sample, captured only on a frame tick
//                enable      - streaming enable (frame timer held at 0 if low)
//                tx          - UART line, idle high, driven from a flop
//                busy        - high while a packet is being serialized
//                overrun     - sticky; a tick arrived while not idle
//                frame_count - packets fully transmitted (16-bit wrap)
//  Revision    : 1.0 - initial release
// ============================================================================
module velocity_uart_streamer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FRAME_PERIOD = 30000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] vel_in,
    input  logic        enable,
    output logic        tx,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] frame_count
);

    localparam int                    c_BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam int                    c_TIMER_W    = $clog2(FRAME_PERIOD);
    localparam logic [c_BAUD_W-1:0]   c_BAUD_LAST  = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_TIMER_W-1:0]  c_TIMER_LAST = c_TIMER_W'(FRAME_PERIOD - 1);
    localparam logic [7:0]            c_SYNC       = 8'hA5;
    localparam logic [2:0]            c_LAST_BYTE  = 3'd4;
    localparam logic [2:0]            c_LAST_BIT   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_BAUD_W-1:0]    r_baud;
    logic [2:0]             r_bit_idx;
    logic [2:0]             r_byte_idx;
    // Whole packet, B0 in the low byte. Since every byte goes out LSB first,
    // the packet is simply shifted out one bit at a time from bit 0.
    logic [39:0]            r_pkt;
    logic [7:0]             r_seq;
    logic                   r_tx;
    logic                   r_busy;
    logic                   r_overrun;
    logic [15:0]            r_frame_count;

    state_t                 w_state_next;
    logic [c_BAUD_W-1:0]    w_baud_next;
    logic [2:0]             w_bit_next;
    logic [2:0]             w_byte_next;
    logic                   w_tx_next;
    logic                   w_busy_next;
    logic                   w_shift;
    logic                   w_load;
    logic                   w_count;
    logic                   w_tick;
    logic                   w_baud_end;
    logic [7:0]             w_chk;

    assign w_tick     = enable && (r_timer == c_TIMER_LAST);
    assign w_baud_end = (r_baud == c_BAUD_LAST);
    assign w_chk      = r_seq ^ vel_in[15:8] ^ vel_in[7:0];

    // Next-state logic. tx is computed for the state being entered so that
    // the line changes on the same edge as the state register.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + 1'b1;
        w_bit_next   = r_bit_idx;
        w_byte_next  = r_byte_idx;
        w_tx_next    = r_tx;
        w_busy_next  = r_busy;
        w_shift      = 1'b0;
        w_load       = 1'b0;
        w_count      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_baud_next = '0;
                if (w_tick) begin
                    w_load       = 1'b1;
                    w_state_next = ST_START;
                    w_byte_next  = 3'd0;
                    w_tx_next    = 1'b0;
                    w_busy_next  = 1'b1;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_state_next = ST_DATA;
                    w_bit_next   = 3'd0;
                    w_tx_next    = r_pkt[0];
                    w_shift      = 1'b1;
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_next = ST_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                        w_tx_next  = r_pkt[0];
                        w_shift    = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (r_byte_idx == c_LAST_BYTE) begin
                        // busy drops on entry to DONE; DONE itself is not busy
                        w_state_next = ST_DONE;
                        w_busy_next  = 1'b0;
                    end else begin
                        // next start bit follows the stop bit with no gap
                        w_state_next = ST_START;
                        w_byte_next  = r_byte_idx + 3'd1;
                        w_tx_next    = 1'b0;
                    end
                end
            end
            ST_DONE: begin
                w_baud_next  = '0;
                w_state_next = ST_IDLE;
                w_count      = 1'b1;
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = ST_IDLE;
                w_tx_next    = 1'b1;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_timer       <= '0;
            r_baud        <= '0;
            r_bit_idx     <= '0;
            r_byte_idx    <= '0;
            r_pkt         <= '0;
            r_seq         <= '0;
            r_tx          <= 1'b1;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            // Frame timer: free-runs 0..FRAME_PERIOD-1 while enabled
            if (!enable || (r_timer == c_TIMER_LAST)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end

            r_state    <= w_state_next;
            r_baud     <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_byte_idx <= w_byte_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;

            if (w_load) begin
                r_pkt <= {w_chk, vel_in[7:0], vel_in[15:8], r_seq, c_SYNC};
                r_seq <= r_seq + 8'd1;
            end else if (w_shift) begin
                r_pkt <= {1'b0, r_pkt[39:1]};
            end

            // Any tick outside IDLE (including the DONE cycle) is a lost sample
            if (w_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end

            if (w_count) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign tx          = r_tx;
    assign busy        = r_busy;
    assign overrun     = r_overrun;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_velocity_uart_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_velocity_uart_streamer
//  Description : Self-checking bench for velocity_uart_streamer. Two
//                instances (frame period 300 and 150) share clock and reset;
//                a UART receiver decodes the selected tx line and decoded
//                packets are compared against packets built from the
//                velocity sampled at each tick and a sequence counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_velocity_uart_streamer;

    localparam int CPB  = 4;
    localparam int FP_A = 300;
    localparam int FP_B = 150;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] vel_a = '0, vel_b = '0;
    logic        en_a = 1'b0, en_b = 1'b0;
    logic        tx_a, busy_a, ovr_a, tx_b, busy_b, ovr_b;
    logic [15:0] fc_a, fc_b;

    velocity_uart_streamer #(.CLKS_PER_BIT(CPB), .FRAME_PERIOD(FP_A)) dut_a (
        .clk(clk), .rst(rst), .vel_in(vel_a), .enable(en_a),
        .tx(tx_a), .busy(busy_a), .overrun(ovr_a), .frame_count(fc_a)
    );

    velocity_uart_streamer #(.CLKS_PER_BIT(CPB), .FRAME_PERIOD(FP_B)) dut_b (
        .clk(clk), .rst(rst), .vel_in(vel_b), .enable(en_b),
        .tx(tx_b), .busy(busy_b), .overrun(ovr_b), .frame_count(fc_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // The receiver and packet tasks look at whichever instance is selected
    logic        sel_b = 1'b0;
    logic        mon_tx, mon_busy;
    logic [15:0] mon_fc;
    assign mon_tx   = sel_b ? tx_b   : tx_a;
    assign mon_busy = sel_b ? busy_b : busy_a;
    assign mon_fc   = sel_b ? fc_b   : fc_a;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  rx_q[$];
    int          rx_t[$];
    logic [7:0]  seq_m = '0;
    logic [15:0] fc_m  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // UART 8N1 receiver: samples mid-bit, records each byte and the cycle
    // its start bit first appeared.
    initial begin
        int         t0;
        logic [7:0] b;
        forever begin
            @(posedge clk); #1;
            if (mon_tx === 1'b0) begin
                t0 = cyc;
                repeat (CPB / 2) @(posedge clk);
                #1;
                check_eq("start_bit", {31'd0, mon_tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1;
                    b[i] = mon_tx;
                end
                repeat (CPB) @(posedge clk);
                #1;
                check_eq("stop_bit", {31'd0, mon_tx}, 32'd1);
                rx_q.push_back(b);
                rx_t.push_back(t0);
            end
        end
    end

    // Wait (bounded) for the first start bit of a packet.
    task automatic wait_start(input int exp_cyc);
        while (mon_tx !== 1'b0 && cyc < exp_cyc + 20) begin
            @(posedge clk); #1;
        end
        check_eq("start_cycle", cyc, exp_cyc);
        check_eq("busy_at_start", {31'd0, mon_busy}, 32'd1);
    endtask

    // Let the packet started at cycle s finish and compare it with the
    // reference packet for velocity vel and the model sequence number.
    task automatic finish_packet(input int s, input logic [15:0] vel);
        logic [7:0] exp_b[5];
        logic [7:0] got;
        int         t;
        exp_b[0] = 8'hA5;
        exp_b[1] = seq_m;
        exp_b[2] = vel[15:8];
        exp_b[3] = vel[7:0];
        exp_b[4] = exp_b[1] ^ exp_b[2] ^ exp_b[3];
        while (mon_busy === 1'b1 && cyc < s + 400) begin
            @(posedge clk); #1;
        end
        check_eq("busy_length", cyc - s, 50 * CPB);
        repeat (2) @(posedge clk);
        #1;
        fc_m = fc_m + 16'd1;
        check_eq("frame_count", {16'd0, mon_fc}, {16'd0, fc_m});
        check_eq("tx_idle", {31'd0, mon_tx}, 32'd1);
        check_eq("rx_bytes", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            got = 8'h00;
            t   = -1;
            if (rx_q.size() > 0) begin
                got = rx_q.pop_front();
                t   = rx_t.pop_front();
            end
            check_eq($sformatf("byte%0d", i), {24'd0, got}, {24'd0, exp_b[i]});
            check_eq($sformatf("byte%0d_start", i), t, s + 10 * CPB * i);
        end
        rx_q.delete();
        rx_t.delete();
        seq_m = seq_m + 8'd1;
    endtask

    initial begin
        int          s, exp_start, bad;
        logic [15:0] cur;

        // Reset with the clock running
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx", {31'd0, tx_a}, 32'd1);
        check_eq("rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("rst_overrun", {31'd0, ovr_a}, 32'd0);
        check_eq("rst_frame_count", {16'd0, fc_a}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back frames: 0x1234, 0xFFFE, then random velocities.
        // vel_a changes right after each start bit, so the in-flight packet
        // must still carry the value sampled at its tick.
        vel_a     = 16'h1234;
        en_a      = 1'b1;
        exp_start = cyc + FP_A;
        for (int k = 0; k < 6; k++) begin
            wait_start(exp_start);
            s     = cyc;
            cur   = vel_a;
            vel_a = (k == 0) ? 16'hFFFE : 16'($urandom);
            finish_packet(s, cur);
            exp_start = s + FP_A;
        end
        check_eq("no_overrun", {31'd0, ovr_a}, 32'd0);

        // Asynchronous reset in the middle of byte B2
        wait_start(exp_start);
        s = cyc;
        while (cyc < s + 25 * CPB - 5) begin
            @(posedge clk); #1;
        end
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_tx", {31'd0, tx_a}, 32'd1);
        check_eq("async_rst_busy", {31'd0, busy_a}, 32'd0);
        check_eq("async_rst_frame_count", {16'd0, fc_a}, 32'd0);
        en_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        rx_q.delete();
        rx_t.delete();
        seq_m = '0;
        fc_m  = '0;

        // Restart: sequence and frame count start again from zero; enable
        // is dropped during B1 and the packet must still complete.
        vel_a     = 16'($urandom);
        en_a      = 1'b1;
        exp_start = cyc + FP_A;
        wait_start(exp_start);
        s     = cyc;
        cur   = vel_a;
        vel_a = 16'($urandom);
        repeat (12 * CPB) @(posedge clk);
        #1;
        en_a = 1'b0;
        finish_packet(s, cur);

        bad = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        check_eq("quiet_while_disabled", bad, 0);

        en_a      = 1'b1;
        exp_start = cyc + FP_A;
        wait_start(exp_start);
        s   = cyc;
        cur = vel_a;
        finish_packet(s, cur);
        en_a = 1'b0;

        // Short frame period: the second tick lands mid-packet and is lost
        sel_b = 1'b1;
        seq_m = '0;
        fc_m  = '0;
        repeat (5) @(posedge clk);
        #1;
        vel_b     = 16'h0005;
        en_b      = 1'b1;
        exp_start = cyc + FP_B;
        wait_start(exp_start);
        s = cyc;
        check_eq("overrun_before", {31'd0, ovr_b}, 32'd0);
        vel_b = 16'($urandom);
        finish_packet(s, 16'h0005);
        check_eq("overrun_set", {31'd0, ovr_b}, 32'd1);
        cur   = 16'($urandom);
        vel_b = cur;
        wait_start(s + 2 * FP_B);
        s = cyc;
        finish_packet(s, cur);
        check_eq("overrun_sticky", {31'd0, ovr_b}, 32'd1);
        en_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/velocity_uart_streamer.md
Name: velocity_uart_streamer

Overview:
- Downstream consumer of the neural pipeline's 16-bit signed decoded velocity output.
- Samples the velocity at a fixed frame period and wraps each sample in a 5-byte packet.
- Serializes packets over a UART 8N1 line to the host, for logging and closed-loop monitoring.
- Contains a frame timer, a packet sequencer FSM, a baud/bit serializer and overrun detection.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range 2 or more.
- FRAME_PERIOD, 30000, clock cycles between velocity samples (20 bins of 1500); legal range 2 or more.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- vel_in  in  16  signed velocity from the decoder; sampled only at a frame tick
- enable  in  1  streaming enable
- tx  out  1  UART serial line; idle high
- busy  out  1  high while a packet is being serialized
- overrun  out  1  sticky; set when a frame tick arrives while busy
- frame_count  out  16  number of packets fully transmitted; wraps at 65535 to 0

Behaviour:
- Reset (async, active-high), effective immediately, including mid-packet:
  - tx=1, busy=0, overrun=0, frame_count=0.
  - seq=0, frame timer=0, FSM=IDLE.
- Frame timer:
  - Counts 0..FRAME_PERIOD-1 while enable=1, then wraps to 0.
  - Held at 0 while enable=0.
  - frame tick = (timer==FRAME_PERIOD-1) and enable.
  - First tick occurs on the FRAME_PERIOD-th rising edge after enable goes high.
- On a tick with FSM=IDLE:
  - Snapshot vel_in.
  - Load the packet: B0=0xA5, B1=seq, B2=vel[15:8], B3=vel[7:0], B4=B1^B2^B3.
  - busy=1 and FSM=START on the next edge; seq increments by 1 (8-bit wrap).
- On a tick with FSM not IDLE:
  - Sample dropped; overrun set to 1; no change to seq or to the packet in flight.
  - overrun clears only on reset.
- FSM states: IDLE -> START -> DATA -> STOP -> (NEXT byte ? START : DONE) -> IDLE.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - After STOP of B4, DONE lasts one cycle: frame_count += 1, busy=0, then IDLE.
- Timing:
  - tx is registered. The start bit of B0 appears the cycle after the tick edge (latency 1 cycle).
  - Bytes are back to back, with no idle gap between the stop bit and the next start bit.
  - Packet duration = 50*CLKS_PER_BIT cycles plus the 1-cycle DONE.
- Enable behaviour:
  - enable falling mid-packet does not abort; the packet completes normally.
  - No new ticks occur while enable is low.
- A tick in the same cycle as DONE counts as busy and raises overrun.
- tx is glitch-free and is driven directly from a flop.
- Configuration guidance: FRAME_PERIOD must exceed 50*CLKS_PER_BIT+1 for lossless streaming; this is not checked in hardware.

Test Plan (CLKS_PER_BIT=4, FRAME_PERIOD=300 unless noted):
1. Assert rst with clocks running -> tx=1, busy=0, overrun=0, frame_count=0. Assert rst asynchronously between edges -> outputs change before the next edge.
2. vel_in=0x1234, enable=1 -> tx falls the cycle after the tick. UART decoder receives A5 00 12 34 26. busy stays high 200 cycles. frame_count=1 after DONE.
3. Continue with vel_in=0xFFFE (-2) -> second packet A5 01 FF FE 00. frame_count=2. overrun stays 0.
4. FRAME_PERIOD=150, vel_in=0x0005 -> first packet sent. Second tick arrives at 150 cycles while busy: overrun=1, that sample is not sent. Next packet carries seq 01, not 02.
5. Assert rst during B2 of a packet -> tx=1 immediately, busy=0. After release and re-enable, the next packet has seq 00 and frame_count counts from 0.
6. Drop enable mid-B1 -> the packet completes (frame_count increments) and no further packets occur for 1000 cycles. Re-raise enable -> the next start bit arrives 300 cycles later.
